// File: rtl/mac_driver.sv
// Operand-side sequencer for one systolic `mac` PE: reads operand pairs,
// frames them with start/stop, and returns the PE accumulator on a valid/ready port.
module mac_driver #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_w,
  input  logic [31:0]       rd_im,
  output logic              mac_start,
  output logic              mac_stop,
  output logic [31:0]       mac_w,
  output logic [31:0]       mac_im,
  input  logic [31:0]       mac_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [2:0]        dbg_state
);

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready;
  // a result transfers on an edge where res_valid && res_ready. cmd_ready is
  // high only in IDLE; res_valid is high only in OUT and res_data is stable there.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic              dv;

  assign rd_addr   = addr;
  assign mac_w     = rd_w;
  assign mac_im    = rd_im;
  assign dbg_state = state;

  // rem counts reads still to issue, including the one on rd_addr while rd_en is high.
  // mac_stop is registered as ~rd_en so that it equals ~dv in the following cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rd_en     <= 1'b0;
      addr      <= '0;
      rem       <= '0;
      dv        <= 1'b0;
      mac_start <= 1'b0;
      mac_stop  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      dv <= rd_en;
      if (rd_en) begin
        addr  <= addr + ADDR_ONE;
        rem   <= rem - LEN_ONE;
        rd_en <= (rem != LEN_ONE);
      end
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= CLEAR;
            cmd_ready <= 1'b0;
            addr      <= cmd_base;
            rem       <= cmd_len;
            rd_en     <= (cmd_len != LEN_ZERO);
            mac_start <= 1'b1;
            mac_stop  <= 1'b1;
          end
        end
        CLEAR: begin
          mac_start <= 1'b0;
          mac_stop  <= ~rd_en;
          state     <= rd_en ? RUN : DRAIN;
        end
        RUN: begin
          mac_stop <= ~rd_en;
          // rd_en low here means this is the last operand-valid cycle
          if (!rd_en) state <= DRAIN;
        end
        DRAIN: begin
          mac_stop  <= 1'b1;
          res_data  <= mac_p;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rd_en     <= 1'b0;
          mac_start <= 1'b0;
          mac_stop  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_driver.sv
// Bench for mac_driver: behavioural PE and operand memory around the DUT,
// dot products predicted directly from memory contents.
module tb_mac_driver;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_base;
  logic [9:0]  cmd_len;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_w;
  logic [31:0] rd_im;
  logic        mac_start;
  logic        mac_stop;
  logic [31:0] mac_w;
  logic [31:0] mac_im;
  logic [31:0] mac_p;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] w_mem  [1024];
  logic [31:0] im_mem [1024];
  logic [31:0] pe_d;
  logic [31:0] exp_q [$];

  // observations collected by run_cmd
  int          start_q [$];
  int          stoplow_q [$];
  int          rd_cyc_q [$];
  logic [9:0]  rd_addr_q [$];
  int          obs_lat;
  logic [31:0] obs_data;
  int          obs_bp_bad;
  int          obs_busy_rdy;
  logic        obs_rdy_offer;
  logic        obs_rdy_after;
  logic        obs_valid_after;
  logic        obs_timeout;

  mac_driver #(.ADDR_W(10), .LEN_W(10)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_w(rd_w), .rd_im(rd_im),
    .mac_start(mac_start), .mac_stop(mac_stop), .mac_w(mac_w), .mac_im(mac_im), .mac_p(mac_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dbg_state(dbg_state)
  );

  // clock / environment
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_w  <= w_mem[rd_addr];
      rd_im <= im_mem[rd_addr];
    end
  end

  assign mac_p = pe_d;
  always @(posedge clk) begin
    if (mac_start)      pe_d <= 32'd0;
    else if (!mac_stop) pe_d <= pe_d + mac_im * mac_w;
  end

  function automatic logic [31:0] model_dot(input logic [9:0] base, input int len);
    logic [31:0] acc;
    logic [9:0]  a;
    acc = 32'd0;
    for (int i = 0; i < len; i++) begin
      a = base + 10'(i);
      acc = acc + w_mem[a] * im_mem[a];
    end
    return acc;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      w_mem[i]  = $urandom;
      im_mem[i] = $urandom;
    end
  endtask

  // Driver: called at a negedge; offers one command, logs per-cycle activity,
  // holds res_ready low for `hold` cycles, then takes the result.
  task automatic run_cmd(input logic [9:0] base, input int len, input int hold);
    start_q.delete(); stoplow_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete();
    obs_lat = -1; obs_bp_bad = 0; obs_busy_rdy = 0; obs_timeout = 1'b0;
    obs_rdy_offer = cmd_ready;
    cmd_valid = 1'b1; cmd_base = base; cmd_len = 10'(len);
    @(negedge clk);
    cmd_base = 10'($urandom); cmd_len = 10'($urandom);
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      if (mac_start) start_q.push_back(cyc);
      if (!mac_stop) stoplow_q.push_back(cyc);
      if (rd_en) begin
        rd_addr_q.push_back(rd_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (cmd_ready) obs_busy_rdy++;
      if (res_valid) begin
        obs_lat = cyc;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    obs_data = res_data;
    if (obs_lat < 0) begin
      obs_timeout = 1'b1;
      return;
    end
    repeat (hold) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== obs_data || cmd_ready !== 1'b0) obs_bp_bad++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    obs_rdy_after   = cmd_ready;
    obs_valid_after = res_valid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rd_en !== 1'b0 || mac_start !== 1'b0 || mac_stop !== 1'b1 ||
        res_valid !== 1'b0 || res_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b rd_en=%b start=%b stop=%b valid=%b data=%h want 1 0 0 1 0 0",
               cmd_ready, rd_en, mac_start, mac_stop, res_valid, res_data);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    w_mem[0] = 32'sd2;  w_mem[1] = -32'sd3; w_mem[2] = 32'sd4;
    im_mem[0] = 32'sd5; im_mem[1] = 32'sd6; im_mem[2] = -32'sd1;
    run_cmd(10'd0, 3, 0);
    checks++;
    if (obs_timeout || obs_data !== 32'hFFFF_FFF4) begin
      errors++; $display("FAIL basic_data got %h want fffffff4 (timeout=%b)", obs_data, obs_timeout);
    end
    checks++;
    if (obs_lat != 6) begin
      errors++; $display("FAIL basic_latency got %0d want 6", obs_lat);
    end
    checks++;
    if (stoplow_q.size() != 3 || stoplow_q[0] != 2 || stoplow_q[1] != 3 || stoplow_q[2] != 4) begin
      errors++; $display("FAIL basic_stop_window got %p want '{2,3,4}", stoplow_q);
    end
    checks++;
    if (start_q.size() != 1 || start_q[0] != 1) begin
      errors++; $display("FAIL basic_start got %p want '{1}", start_q);
    end
    bad = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] !== 10'(i) || rd_cyc_q[i] != i + 1) bad++;
    checks++;
    if (rd_addr_q.size() != 3 || bad != 0) begin
      errors++; $display("FAIL basic_reads got addr %p cyc %p want 0,1,2 at 1,2,3", rd_addr_q, rd_cyc_q);
    end
    checks++;
    if (obs_busy_rdy != 0 || obs_rdy_after !== 1'b1 || obs_valid_after !== 1'b0) begin
      errors++; $display("FAIL basic_handshake got busy_rdy=%0d rdy_after=%b valid_after=%b want 0 1 0",
                         obs_busy_rdy, obs_rdy_after, obs_valid_after);
    end
  endtask

  task automatic test_zero_len();
    run_cmd(10'd5, 0, 0);
    checks++;
    if (obs_timeout || obs_lat != 3 || obs_data !== 32'd0) begin
      errors++; $display("FAIL zero_len_result got lat=%0d data=%h want lat=3 data=0", obs_lat, obs_data);
    end
    checks++;
    if (start_q.size() != 1 || start_q[0] != 1 || rd_addr_q.size() != 0 || stoplow_q.size() != 0) begin
      errors++; $display("FAIL zero_len_pulses got starts=%p reads=%0d stoplow=%0d want '{1} 0 0",
                         start_q, rd_addr_q.size(), stoplow_q.size());
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp;
    fill_random();
    exp = model_dot(10'd1022, 4);
    run_cmd(10'd1022, 4, 1);
    checks++;
    if (rd_addr_q.size() != 4 || rd_addr_q[0] !== 10'd1022 || rd_addr_q[1] !== 10'd1023 ||
        rd_addr_q[2] !== 10'd0 || rd_addr_q[3] !== 10'd1) begin
      errors++; $display("FAIL wrap_addrs got %p want '{1022,1023,0,1}", rd_addr_q);
    end
    checks++;
    if (obs_timeout || obs_data !== exp) begin
      errors++; $display("FAIL wrap_data got %h want %h", obs_data, exp);
    end
  endtask

  task automatic test_overflow();
    w_mem[50] = 32'h0001_0000; im_mem[50] = 32'h0001_0000;
    w_mem[51] = 32'h0001_0000; im_mem[51] = 32'h0001_0000;
    run_cmd(10'd50, 2, 0);
    checks++;
    if (obs_timeout || obs_data !== 32'd0) begin
      errors++; $display("FAIL overflow_data got %h want 00000000", obs_data);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0]  base;
    logic [31:0] exp;
    base = 10'($urandom_range(0, 1023));
    exp = model_dot(base, 5);
    run_cmd(base, 5, 5);
    checks++;
    if (obs_timeout || obs_data !== exp) begin
      errors++; $display("FAIL bp_data got %h want %h", obs_data, exp);
    end
    checks++;
    if (obs_bp_bad != 0 || obs_rdy_after !== 1'b1) begin
      errors++; $display("FAIL bp_hold got unstable_cycles=%0d rdy_after=%b want 0 1", obs_bp_bad, obs_rdy_after);
    end
    base = 10'($urandom_range(0, 1023));
    exp = model_dot(base, 3);
    run_cmd(base, 3, 0);
    checks++;
    if (obs_rdy_offer !== 1'b1 || obs_timeout || obs_data !== exp) begin
      errors++; $display("FAIL bp_next_cmd got rdy=%b data=%h want 1 %h", obs_rdy_offer, obs_data, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    cmd_valid = 1'b1; cmd_base = 10'd300; cmd_len = 10'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0 || mac_stop !== 1'b1 || res_valid !== 1'b0 || cmd_ready !== 1'b1 ||
        mac_start !== 1'b0 || res_data !== 32'd0) begin
      errors++; $display("FAIL reset_mid_outputs got rd_en=%b stop=%b valid=%b rdy=%b start=%b data=%h want 0 1 0 1 0 0",
                         rd_en, mac_stop, res_valid, cmd_ready, mac_start, res_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp = model_dot(10'd700, 2);
    run_cmd(10'd700, 2, 0);
    checks++;
    if (obs_timeout || obs_data !== exp || obs_lat != 5) begin
      errors++; $display("FAIL reset_mid_next got data=%h lat=%0d want %h lat=5", obs_data, obs_lat, exp);
    end
  endtask

  task automatic test_random();
    logic [9:0]  base;
    logic [31:0] exp;
    int len, hold, bad;
    fill_random();
    for (int k = 0; k < 20; k++) begin
      base = 10'($urandom_range(0, 1023));
      len  = $urandom_range(0, 40);
      hold = $urandom_range(0, 3);
      exp_q.push_back(model_dot(base, len));
      run_cmd(base, len, hold);
      exp = exp_q.pop_front();
      checks++;
      if (obs_timeout || obs_data !== exp || obs_lat != len + 3) begin
        errors++; $display("FAIL rand_result[%0d] got data=%h lat=%0d want %h lat=%0d", k, obs_data, obs_lat, exp, len + 3);
      end
      bad = 0;
      foreach (stoplow_q[i]) if (stoplow_q[i] != i + 2) bad++;
      foreach (rd_addr_q[i]) if (rd_addr_q[i] !== base + 10'(i) || rd_cyc_q[i] != i + 1) bad++;
      checks++;
      if (stoplow_q.size() != len || rd_addr_q.size() != len || bad != 0 || obs_bp_bad != 0 ||
          obs_busy_rdy != 0 || obs_rdy_after !== 1'b1) begin
        errors++; $display("FAIL rand_timing[%0d] got stoplow=%0d reads=%0d bad=%0d bp=%0d busy_rdy=%0d rdy_after=%b want len=%0d",
                           k, stoplow_q.size(), rd_addr_q.size(), bad, obs_bp_bad, obs_busy_rdy, obs_rdy_after, len);
      end
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; res_ready = 1'b0;
    rd_w = '0; rd_im = '0; pe_d = 32'hDEAD_BEEF;
    fill_random();
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_len();
    test_addr_wrap();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_driver.md
# mac_driver

Sequencer that drives one systolic-array `mac` processing element from the operand side and collects its result. It accepts a dot-product command (base address, length) and issues synchronous reads to the weight/image operand memory. It sequences `start`/`stop` and streams operands into the PE, then captures the PE's 32-bit accumulator and returns it through a valid/ready result port. It sits between the MNIST layer controller and each PE.

## Interface

**Parameters**
- `ADDR_W`, default 10: operand memory address width.
- `LEN_W`, default 10: command length width. Lengths 0..2^LEN_W-1 are legal.

**Ports**
- `clk` in, 1: single clock. All logic is on the rising edge.
- `resetn` in, 1: reset, asynchronous, active-low.
- `cmd_valid` in, 1: command offered.
- `cmd_ready` out, 1: high only in IDLE.
- `cmd_base` in, ADDR_W: first operand address.
- `cmd_len` in, LEN_W: number of products N.
- `rd_en` out, 1: operand read strobe. Memory returns data one cycle later.
- `rd_addr` out, ADDR_W: operand address.
- `rd_w` in, 32: weight read data, signed.
- `rd_im` in, 32: image read data, signed.
- `mac_start` out, 1: clears the PE accumulator. Has priority over `mac_stop` in the PE.
- `mac_stop` out, 1: holds the PE accumulator.
- `mac_w` out, 32: combinational pass-through of `rd_w`.
- `mac_im` out, 32: combinational pass-through of `rd_im`.
- `mac_p` in, 32: PE accumulator.
- `res_valid` out, 1: result available.
- `res_ready` in, 1: result consumer ready.
- `res_data` out, 32: captured dot product.

## Operation

**Behaviour of the PE being driven**
- Every rising edge, the PE updates its accumulator:
  - `start` high: d ← 0.
  - else `stop` high: d holds.
  - else: d ← p + im·w.
- The PE is therefore required to see `mac_stop`=1 on every cycle without valid operands.

**States**
- IDLE:
  - Outputs: `cmd_ready`=1, `mac_stop`=1, `mac_start`=0, `rd_en`=0.
  - On `cmd_valid`&&`cmd_ready`: latch base into `addr`, latch len into `rem`, go to CLEAR.
- CLEAR (1 cycle):
  - `mac_start`=1, `mac_stop`=1.
  - If `rem`≠0: `rd_en`=1, `rd_addr`=`addr`, then `addr`++ and `rem`--.
  - Next state: RUN if len≠0, else DRAIN.
- RUN:
  - While `rem`≠0: `rd_en`=1 each cycle with the next address.
  - `dv` (registered copy of `rd_en`) marks operand-valid cycles.
  - `mac_stop` = ~`dv`, `mac_start`=0.
  - Go to DRAIN in the cycle after the last `dv` cycle.
- DRAIN (1 cycle):
  - `mac_stop`=1.
  - `res_data` ← `mac_p`.
  - Go to OUT.
- OUT:
  - `res_valid`=1, `mac_stop`=1.
  - `res_data` stays stable.
  - On `res_ready`: go to IDLE.

**Arithmetic and width rules**
- Addresses wrap modulo 2^ADDR_W.
- The result is the PE's low 32 bits: signed two's-complement wrap, not saturated. The driver passes `mac_p` through unmodified.

**Reset**
- Asserting `resetn` low at any time:
  - state → IDLE.
  - `res_valid`, `rd_en`, `mac_start` → 0.
  - `mac_stop` → 1.
  - `res_data` → 0.
  - `rem`, `addr`, `dv` → 0.
- An in-flight command is dropped and no result is produced.
- The PE has no reset. The next command's CLEAR cycle reinitialises it.

## Timing

**Sequence**, counting the accept edge as cycle 0 and N = len:
- Cycle 1: CLEAR. Read of addr base+0 issued.
- Cycles 1..N: reads of base+0..base+N-1 issued.
- Cycles 2..N+1: `dv`=1 and `mac_stop`=0. The PE accumulates at the end of each of these cycles.
- Cycle N+2: DRAIN. `mac_p` holds the final sum.
- Cycle N+3 onward: `res_valid`=1.

**Latency**
- Command accept to `res_valid` is N+3 cycles.
- N=0: `res_valid` at cycle 3 with `res_data`=0.

**Handshakes**
- Accepting a command requires both `cmd_valid` and `cmd_ready` high at the same edge.
- A result transfer requires both `res_valid` and `res_ready` high at the same edge.
- `res_ready` held low: stay in OUT indefinitely with `res_data` and `res_valid` stable and `cmd_ready`=0.
- After the result transfer edge, `cmd_ready`=1 in the next cycle. There is no same-cycle result-then-command overlap.
- `cmd_*` inputs are ignored outside IDLE.
- No read stalls: the memory responds every cycle.

## Test plan

- **Basic dot product.** N=3, base=0.
  - Stimulus: w={2,−3,4}, im={5,6,−1}.
  - Required: `res_data`=0xFFFFFFF4 (−12) with `res_valid` high at cycle 6.
  - Required: `mac_stop` low exactly in cycles 2–4.
- **Zero length.** N=0.
  - Required: exactly one `mac_start` pulse (cycle 1) and no `rd_en`.
  - Required: `res_valid` at cycle 3 with `res_data`=0.
  - Repeat after a prior nonzero result to confirm the PE is cleared.
- **Address wrap.** base=1022, N=4.
  - Required: `rd_addr` sequence 1022, 1023, 0, 1.
- **Overflow wrap.** N=2, w=im=0x00010000.
  - Required: `res_data`=0x00000000 (2^33 wraps to 0).
- **Backpressure.** Hold `res_ready` low 5 cycles in OUT.
  - Required: `res_valid`=1, `res_data` constant, `cmd_ready`=0 throughout.
  - Release `res_ready`: IDLE next cycle. A command offered then is accepted.
- **Reset mid-run.** Assert `resetn` low during RUN of an N=8 command.
  - Required immediately: `rd_en`=0, `mac_stop`=1, `res_valid`=0, `cmd_ready`=1.
  - Required: the next N=2 command yields the correct sum with no residue from the aborted command.
